// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: phase sequencer for the multi-cycle MIPS datapath with retired counter and illegal-opcode flag
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        irwe,
  output logic        pcwe,
  output logic        rfwe,
  output logic        dmwe,
  output logic [1:0]  npcop,
  output logic [1:0]  wrsel,
  output logic [1:0]  wdsel,
  output logic [1:0]  extop,
  output logic        asel,
  output logic        bsel,
  output logic [4:0]  aluop,
  output logic [1:0]  dmtype,
  output logic [31:0] retired,
  output logic        bad_instr
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t st, nxt;
  logic is_r, is_addu, is_subu, is_sll, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_bad, in_instr, short_path;
  logic unused_zero;
  // beq resolution happens in the NPC unit, so zero only feeds the datapath
  assign unused_zero = zero;
  assign is_r = opcode == 6'h00;
  assign is_addu = is_r && funct == 6'h21;
  assign is_subu = is_r && funct == 6'h23;
  assign is_sll = is_r && funct == 6'h00;
  assign is_jr = is_r && funct == 6'h08;
  assign is_ori = opcode == 6'h0d;
  assign is_lui = opcode == 6'h0f;
  assign is_lw = opcode == 6'h23;
  assign is_sw = opcode == 6'h2b;
  assign is_beq = opcode == 6'h04;
  assign is_j = opcode == 6'h02;
  assign is_jal = opcode == 6'h03;
  assign is_bad = !(is_addu || is_subu || is_sll || is_jr || is_ori || is_lui ||
                    is_lw || is_sw || is_beq || is_j || is_jal);
  assign short_path = is_j || is_jal || is_jr || is_bad;
  assign in_instr = st != FETCH;
  assign state = st;
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:   nxt = DECODE;
      DECODE:  nxt = short_path ? FETCH : EXEC;
      EXEC:    nxt = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
      MEM:     nxt = !mem_ready ? MEM : is_lw ? WB : FETCH;
      default: nxt = FETCH;
    endcase
  end
  // Enables are gated by reset so a mid-instruction reset never leaves a partial write
  always_comb begin
    irwe = reset && st == FETCH;
    pcwe = reset && ((st == DECODE && short_path) || (st == EXEC && is_beq) ||
                     (st == MEM && is_sw && mem_ready) || st == WB);
    rfwe = reset && ((st == DECODE && is_jal) || st == WB);
    dmwe = reset && st == MEM && is_sw;
    npcop = !in_instr ? 2'd0 : (is_j || is_jal) ? 2'd2 : is_jr ? 2'd3 : is_beq ? 2'd1 : 2'd0;
    wrsel = !in_instr ? 2'd0 : is_jal ? 2'd2 : (is_addu || is_subu || is_sll) ? 2'd1 : 2'd0;
    wdsel = !in_instr ? 2'd0 : is_jal ? 2'd2 : is_lw ? 2'd1 : 2'd0;
    extop = !in_instr ? 2'd0 : is_sll ? 2'd3 : is_lui ? 2'd2 : (is_lw || is_sw) ? 2'd1 : 2'd0;
    asel = in_instr && is_sll;
    bsel = in_instr && (is_ori || is_lui || is_lw || is_sw);
    aluop = !in_instr ? 5'd0 : (is_subu || is_beq) ? 5'd1 : (is_ori || is_lui) ? 5'd2 :
            is_sll ? 5'd3 : 5'd0;
    dmtype = 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= FETCH;
      retired <= '0;
      bad_instr <= 1'b0;
    end else begin
      st <= nxt;
      if (pcwe) retired <= retired + 32'd1;
      if (st == DECODE && is_bad) bad_instr <= 1'b1;
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the team's MIPS datapath (PC, NPC, IM, RF, ALU, DM, EXT). It replaces the single-cycle decoder: each instruction is split into FETCH/DECODE/EXEC/MEM/WB phases, and architectural writes are issued only in the phase where their operands are valid. The block also holds data memory through a ready handshake and keeps a retired-instruction counter and a sticky illegal-opcode flag. Datapath muxes consume the select encodings below unchanged.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low (reset asserted when 0, sampled on rising edge of clk).
- opcode  input  6  IR[31:26], stable from the DECODE cycle onward.
- funct  input  6  IR[5:0].
- zero  input  1  ALU equality flag (beq).
- mem_ready  input  1  DM access complete this cycle.
- state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- irwe, pcwe, rfwe, dmwe  output  1 each  IR/PC/RF/DM write enables.
- npcop  output  2  0=pc+4, 1=branch (taken if zero), 2=j/jal target, 3=rs (jr).
- wrsel  output  2  0=rt, 1=rd, 2=$31.
- wdsel  output  2  0=ALU, 1=DM, 2=pc+4.
- extop  output  2  0=zero-ext, 1=sign-ext, 2=imm<<16, 3=shamt (IR[10:6]).
- asel, bsel  output  1 each  asel 0=rs/1=EXT; bsel 0=rt/1=EXT.
- aluop  output  5  0=add, 1=sub, 2=or, 3=sll (b<<a[4:0]).
- dmtype  output  2  always 0 (word).
- retired  output  32  count of pcwe pulses since reset.
- bad_instr  output  1  sticky: an unsupported instruction was decoded.

## Operation
- Supported: R-type (opcode 0) addu (funct 0x21), subu (0x23), sll (0x00), jr (0x08); ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03. All else is unsupported.
- Phase sequences (PC holds the current instruction address throughout; PC updates only on pcwe):
  - addu/subu/sll/ori/lui: F, D, E, W. rfwe=1 and pcwe=1 (npcop=0) in W.
  - lw: F, D, E, M, W. M repeats until mem_ready=1; W: rfwe=1, wdsel=1, wrsel=0, pcwe=1.
  - sw: F, D, E, M. dmwe=1 in every M cycle; pcwe=1 only in the M cycle where mem_ready=1; then F.
  - beq: F, D, E. E: aluop=1, pcwe=1, npcop=1.
  - j: F, D with pcwe=1, npcop=2. jal: same plus rfwe=1, wrsel=2, wdsel=2. jr: F, D with pcwe=1, npcop=3.
  - unsupported: F, D with pcwe=1, npcop=0, no other writes; bad_instr set at that edge.
- Selects: addu aluop0/bsel0/wrsel1; subu aluop1/bsel0/wrsel1; sll asel1/extop3/bsel0/aluop3/wrsel1; ori extop0/bsel1/aluop2/wrsel0; lui extop2/bsel1/aluop2/wrsel0; lw/sw extop1/bsel1/aluop0; beq bsel0/aluop1.
- FETCH: irwe=1; every other output except state/retired/bad_instr is 0. irwe=0 outside FETCH.
- Control outputs are combinational from registered state plus opcode/funct. In non-write phases, selects keep the instruction's values; all enables are 0.
- retired += 1 (mod 2^32, wraps) on every edge where pcwe=1.

## Timing
- Reset (reset=0 at an edge): state=FETCH, retired=0, bad_instr=0. While reset=0, all enables (irwe, pcwe, rfwe, dmwe) are forced to 0 combinationally. This covers reset arriving mid-instruction, including in MEM: no partial write is issued and the next instruction starts with a fresh FETCH.
- First FETCH occurs in the cycle after reset deasserts.
- Latency in cycles: jumps/unsupported 2, beq 3, ALU ops 4, sw 4+k, lw 5+k, where k = extra M cycles before mem_ready.
- mem_ready is ignored outside MEM. mem_ready=1 on the first M cycle gives k=0.
- bad_instr clears only on reset.

## Test plan
- addu $3,$1,$2 (opcode 0, funct 0x21) -> state 0,1,2,4; rfwe=1, wrsel=1, wdsel=0 only in the 4th cycle; pcwe once; retired 0->1.
- lw with mem_ready low for 2 M cycles -> states 0,1,2,3,3,3,4; rfwe/wdsel=1 in W only; total 7 cycles.
- sw with mem_ready=1 immediately -> dmwe=1 for exactly 1 cycle in M, pcwe in the same cycle, next state 0.
- beq with zero=1 then zero=0 -> each 3 cycles, pcwe=1, npcop=1 in E; retired +2.
- jal -> D cycle: pcwe=1, npcop=2, rfwe=1, wrsel=2, wdsel=2; opcode 0x3F -> pcwe in D, bad_instr=1 and stays 1 through subsequent instructions.
- reset=0 during lw's 2nd M cycle -> enables 0 that cycle; state=0, retired=0, bad_instr=0 after the edge; no rfwe observed.
